// File: rtl/fpu8087_direct.sv
// x87 register-stack unit driven directly by the CPU: constant loads, sign ops, register moves, 80-bit transfers.
// Latency 1 cycle per cpu_execute; never back-pressures (cpu_ready stays high).
module fpu8087_direct (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cpu_opcode,
  input  logic [7:0]  cpu_modrm,
  input  logic        cpu_execute,
  output logic        cpu_ready,
  output logic        cpu_error,
  input  logic [79:0] cpu_data_in,
  output logic [79:0] cpu_data_out,
  input  logic [31:0] cpu_int_data_in,
  output logic [31:0] cpu_int_data_out,
  input  logic [15:0] cpu_control_in,
  input  logic        cpu_control_write,
  output logic [15:0] cpu_status_out,
  output logic [15:0] cpu_control_out,
  output logic [15:0] cpu_tag_word_out
);
  localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;
  localparam logic [1:0]  TAG_EMPTY = 2'b11;

  logic [79:0]     regs [8];
  logic [7:0][1:0] tags, tags_n;
  logic [15:0]     status, status_n, control, control_n;
  logic [79:0]     data_out, data_out_n;
  logic            ready_q;

  logic [2:0]  top, st_i, push_idx, top_n;
  logic [79:0] st0_val, sti_val;
  logic        st0_empty, sti_empty, push_full;

  logic        wa_en, wb_en, push, pop, store, exc, ovf, finit, abort;
  logic [2:0]  wa_idx, wb_idx;
  logic [79:0] wa_val, wb_val, store_val;

  logic unused_int_in;
  assign unused_int_in = ^cpu_int_data_in;

  function automatic logic [1:0] tag_of(input logic [79:0] v);
    if (v[78:64] == 15'h7FFF) return 2'b10;
    if (v[78:64] == 15'h0000) return (v[63:0] == 64'h0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [79:0] const_of(input logic [2:0] sel);
    case (sel)
      3'd0:    return 80'h3FFF_8000_0000_0000_0000;
      3'd1:    return 80'h4000_D49A_784B_CD1B_8AFE;
      3'd2:    return 80'h3FFF_B8AA_3B29_5C17_F0BC;
      3'd3:    return 80'h4000_C90F_DAA2_2168_C235;
      3'd4:    return 80'h3FFD_9A20_9A84_FBCF_F799;
      3'd5:    return 80'h3FFE_B172_17F7_D1CF_79AC;
      default: return 80'h0;
    endcase
  endfunction

  assign top       = status[13:11];
  assign st_i      = top + cpu_modrm[2:0];
  assign push_idx  = top - 3'd1;
  assign st0_val   = regs[top];
  assign sti_val   = regs[st_i];
  assign st0_empty = (tags[top] == TAG_EMPTY);
  assign sti_empty = (tags[st_i] == TAG_EMPTY);
  assign push_full = (tags[push_idx] != TAG_EMPTY);

  // Decode: each instruction reduces to up to two register writes plus push/pop/store.
  always_comb begin
    wa_en = 1'b0; wa_idx = top;  wa_val = 80'h0;
    wb_en = 1'b0; wb_idx = st_i; wb_val = 80'h0;
    push = 1'b0; pop = 1'b0; store = 1'b0; store_val = 80'h0;
    exc = 1'b0; ovf = 1'b0; finit = 1'b0;
    if (cpu_execute) begin
      if (cpu_opcode == 8'hD9 && cpu_modrm >= 8'hE8 && cpu_modrm <= 8'hEE) begin
        push   = 1'b1;
        wa_val = const_of(cpu_modrm[2:0]);
      end else if (cpu_opcode == 8'hD9 && (cpu_modrm == 8'hE0 || cpu_modrm == 8'hE1)) begin
        wa_en  = 1'b1;
        exc    = st0_empty;
        wa_val = st0_empty ? INDEF
               : {(cpu_modrm[0] ? 1'b0 : ~st0_val[79]), st0_val[78:0]};
      end else if (cpu_opcode == 8'hD9 && cpu_modrm[7:3] == 5'b11000) begin
        push   = 1'b1;
        exc    = sti_empty;
        wa_val = sti_empty ? INDEF : sti_val;
      end else if (cpu_opcode == 8'hD9 && cpu_modrm[7:3] == 5'b11001) begin
        wa_en  = 1'b1;
        wb_en  = 1'b1;
        exc    = st0_empty | sti_empty;
        wa_val = sti_empty ? INDEF : sti_val;
        wb_val = st0_empty ? INDEF : st0_val;
      end else if (cpu_opcode == 8'hDD && cpu_modrm[7:3] == 5'b11011) begin
        wb_en  = 1'b1;
        pop    = 1'b1;
        exc    = st0_empty;
        wb_val = st0_empty ? INDEF : st0_val;
      end else if (cpu_opcode == 8'hDB && cpu_modrm[7:6] != 2'b11 && cpu_modrm[5:3] == 3'd5) begin
        push   = 1'b1;
        wa_val = cpu_data_in;
      end else if (cpu_opcode == 8'hDB && cpu_modrm[7:6] != 2'b11 && cpu_modrm[5:3] == 3'd7) begin
        store  = 1'b1;
      end else if (cpu_opcode == 8'hDB && cpu_modrm == 8'hED) begin
        // Register-form transfer direction is chosen by ST0 occupancy.
        if (st0_empty) begin
          push   = 1'b1;
          wa_val = cpu_data_in;
        end else begin
          store  = 1'b1;
        end
      end else if (cpu_opcode == 8'hDB && cpu_modrm == 8'hE3) begin
        finit  = 1'b1;
      end
    end

    if (store) begin
      pop       = 1'b1;
      exc       = st0_empty;
      store_val = st0_empty ? INDEF : st0_val;
    end
    // Overflow takes precedence over a source underflow on the same push.
    if (push) begin
      wa_en  = 1'b1;
      wa_idx = push_idx;
      if (push_full) begin
        exc    = 1'b1;
        ovf    = 1'b1;
        wa_val = INDEF;
      end
    end

    abort = exc & ~control[0];
    if (abort) begin
      wa_en = 1'b0; wb_en = 1'b0; push = 1'b0; pop = 1'b0; store = 1'b0;
    end

    top_n = push ? push_idx : (pop ? top + 3'd1 : top);

    tags_n = tags;
    if (wa_en) tags_n[wa_idx] = tag_of(wa_val);
    if (wb_en) tags_n[wb_idx] = tag_of(wb_val);
    if (pop)   tags_n[top]    = TAG_EMPTY;

    status_n = status;
    if (exc) begin
      status_n[0] = 1'b1;
      status_n[6] = 1'b1;
      status_n[9] = ovf;
      if (abort) begin
        status_n[7]  = 1'b1;
        status_n[15] = 1'b1;
      end
    end
    status_n[13:11] = top_n;

    control_n  = control;
    data_out_n = store ? store_val : data_out;
    if (finit) begin
      status_n  = 16'h0000;
      control_n = 16'h037F;
      tags_n    = '1;
    end
    if (cpu_control_write) control_n = cpu_control_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 80'h0;
      tags     <= '1;
      status   <= 16'h0000;
      control  <= 16'h037F;
      data_out <= 80'h0;
      ready_q  <= 1'b1;
    end else begin
      if (wa_en) regs[wa_idx] <= wa_val;
      if (wb_en) regs[wb_idx] <= wb_val;
      tags     <= tags_n;
      status   <= status_n;
      control  <= control_n;
      data_out <= data_out_n;
      ready_q  <= 1'b1;
    end
  end

  assign cpu_ready        = ready_q;
  assign cpu_error        = status[7];
  assign cpu_data_out     = data_out;
  assign cpu_int_data_out = {16'h0000, status};
  assign cpu_status_out   = status;
  assign cpu_control_out  = control;
  assign cpu_tag_word_out = tags;
endmodule

// File: tb/tb_fpu8087_direct.sv
// Directed bench for fpu8087_direct: stimulus queues expected state, a probe-triggered monitor compares.
module tb_fpu8087_direct;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cpu_opcode = 8'h0, cpu_modrm = 8'h0;
  logic        cpu_execute = 1'b0;
  logic        cpu_ready, cpu_error;
  logic [79:0] cpu_data_in = 80'h0, cpu_data_out;
  logic [31:0] cpu_int_data_in = 32'h0, cpu_int_data_out;
  logic [15:0] cpu_control_in = 16'h0;
  logic        cpu_control_write = 1'b0;
  logic [15:0] cpu_status_out, cpu_control_out, cpu_tag_word_out;

  fpu8087_direct dut (
    .clk(clk), .reset(reset), .cpu_opcode(cpu_opcode), .cpu_modrm(cpu_modrm),
    .cpu_execute(cpu_execute), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .cpu_int_data_in(cpu_int_data_in), .cpu_int_data_out(cpu_int_data_out),
    .cpu_control_in(cpu_control_in), .cpu_control_write(cpu_control_write),
    .cpu_status_out(cpu_status_out), .cpu_control_out(cpu_control_out),
    .cpu_tag_word_out(cpu_tag_word_out)
  );

  always #5 clk = ~clk;

  localparam logic [79:0] ONE   = 80'h3FFF_8000_0000_0000_0000;
  localparam logic [79:0] PI    = 80'h4000_C90F_DAA2_2168_C235;
  localparam logic [79:0] L2T   = 80'h4000_D49A_784B_CD1B_8AFE;
  localparam logic [79:0] L2E   = 80'h3FFF_B8AA_3B29_5C17_F0BC;
  localparam logic [79:0] LG2   = 80'h3FFD_9A20_9A84_FBCF_F799;
  localparam logic [79:0] LN2   = 80'h3FFE_B172_17F7_D1CF_79AC;
  localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;

  typedef struct {
    string       name;
    logic [79:0] dout;
    logic [15:0] st;
    logic [15:0] tag;
    logic [15:0] ctrl;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic probe = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input logic [79:0] act, input logic [79:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // Monitor: the probe marks a cycle where the DUT outputs must match the next queued expectation.
  always @(posedge clk) begin
    if (probe) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_underrun: probe with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        cmp({mon_e.name, ".data_out"}, cpu_data_out, mon_e.dout);
        cmp({mon_e.name, ".status"},   {64'h0, cpu_status_out}, {64'h0, mon_e.st});
        cmp({mon_e.name, ".tag"},      {64'h0, cpu_tag_word_out}, {64'h0, mon_e.tag});
        cmp({mon_e.name, ".control"},  {64'h0, cpu_control_out}, {64'h0, mon_e.ctrl});
        cmp({mon_e.name, ".error"},    {79'h0, cpu_error}, {79'h0, mon_e.err});
        cmp({mon_e.name, ".ready"},    {79'h0, cpu_ready}, 80'h1);
        cmp({mon_e.name, ".int_out"},  {48'h0, cpu_int_data_out}, {64'h0, mon_e.st});
      end
    end
  end

  task automatic chk(input string nm, input logic [79:0] d, input logic [15:0] st,
                     input logic [15:0] tag, input logic [15:0] ctrl, input logic err);
    exp_t e;
    e.name = nm; e.dout = d; e.st = st; e.tag = tag; e.ctrl = ctrl; e.err = err;
    sb.push_back(e);
    @(posedge clk); #1 probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
  endtask

  task automatic ex(input logic [7:0] op, input logic [7:0] m, input logic [79:0] d = 80'h0);
    @(posedge clk); #1;
    cpu_opcode = op; cpu_modrm = m; cpu_data_in = d; cpu_execute = 1'b1;
    @(posedge clk); #1;
    cpu_execute = 1'b0;
  endtask

  task automatic ex_cw(input logic [7:0] op, input logic [7:0] m, input logic [15:0] cw);
    @(posedge clk); #1;
    cpu_opcode = op; cpu_modrm = m; cpu_execute = 1'b1;
    cpu_control_in = cw; cpu_control_write = 1'b1;
    @(posedge clk); #1;
    cpu_execute = 1'b0; cpu_control_write = 1'b0;
  endtask

  task automatic cw_only(input logic [15:0] cw);
    @(posedge clk); #1;
    cpu_control_in = cw; cpu_control_write = 1'b1;
    @(posedge clk); #1;
    cpu_control_write = 1'b0;
  endtask

  // Reset is held with a push and a control write pending to show it dominates both.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_opcode = 8'hD9; cpu_modrm = 8'hE8; cpu_execute = 1'b1;
    cpu_control_in = 16'h1234; cpu_control_write = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; cpu_execute = 1'b0; cpu_control_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("reset", 80'h0, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    ex(8'hD9, 8'hE8);
    chk("fld1_push", 80'h0, 16'h3800, 16'h3FFF, 16'h037F, 1'b0);
    ex(8'hDB, 8'hED);
    chk("fld1", ONE, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);
    ex(8'hD9, 8'hEE);
    chk("fldz_push", ONE, 16'h3800, 16'h7FFF, 16'h037F, 1'b0);
    ex(8'hDB, 8'hED);
    chk("fldz", 80'h0, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);
    ex(8'hD9, 8'hEB); ex(8'hDB, 8'hED);
    chk("fldpi", PI, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);
    ex(8'hD9, 8'hE9); ex(8'hDB, 8'hED);
    chk("fldl2t", L2T, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);
    ex(8'hD9, 8'hED); ex(8'hDB, 8'hED);
    chk("fldln2", LN2, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);
    ex(8'hD9, 8'hEA); ex(8'hDB, 8'hED);
    chk("fldl2e", L2E, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);
    ex(8'hD9, 8'hEC); ex(8'hDB, 8'hED);
    chk("fldlg2", LG2, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    ex(8'hDB, 8'hED, 80'hC000_A000_0000_0000_0000);
    chk("ld80_reg", LG2, 16'h3800, 16'h3FFF, 16'h037F, 1'b0);
    ex(8'hD9, 8'hE1); ex(8'hDB, 8'hED);
    chk("fabs", 80'h4000_A000_0000_0000_0000, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    ex(8'hDB, 8'h28, 80'h4000_C000_0000_0000_0000);
    ex(8'hD9, 8'hE0); ex(8'hDB, 8'h38);
    chk("fchs_m80", 80'hC000_C000_0000_0000_0000, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);
    ex(8'hDB, 8'hED, 80'h4001_A000_0000_0000_0000);
    ex(8'hD9, 8'hE0); ex(8'hD9, 8'hE0); ex(8'hDB, 8'hED);
    chk("fchs_x2", 80'h4001_A000_0000_0000_0000, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    ex(8'hD9, 8'hE8);
    ex(8'hD9, 8'hD0);
    chk("fnop", 80'h4001_A000_0000_0000_0000, 16'h3800, 16'h3FFF, 16'h037F, 1'b0);
    ex(8'h9B, 8'h00);
    chk("fwait", 80'h4001_A000_0000_0000_0000, 16'h3800, 16'h3FFF, 16'h037F, 1'b0);
    ex(8'hD8, 8'hC1);
    chk("unknown", 80'h4001_A000_0000_0000_0000, 16'h3800, 16'h3FFF, 16'h037F, 1'b0);
    ex(8'hDB, 8'hED);
    chk("pop_after_nop", ONE, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    @(posedge clk); #1;
    cpu_opcode = 8'hD9; cpu_modrm = 8'hEE; cpu_execute = 1'b1;
    repeat (2) @(posedge clk);
    #1 cpu_execute = 1'b0;
    chk("held_execute", ONE, 16'h3000, 16'h5FFF, 16'h037F, 1'b0);
    ex(8'hDB, 8'hED); ex(8'hDB, 8'hED);
    chk("held_pop", 80'h0, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    ex(8'hDB, 8'hED, 80'h4000_C000_0000_0000_0000);
    ex(8'hD9, 8'hE8); ex(8'hD9, 8'hC9); ex(8'hDB, 8'hED);
    chk("fxch", 80'h4000_C000_0000_0000_0000, 16'h3800, 16'h3FFF, 16'h037F, 1'b0);
    ex(8'hD9, 8'hC0); ex(8'hDB, 8'hED);
    chk("fld_st0", ONE, 16'h3800, 16'h3FFF, 16'h037F, 1'b0);
    ex(8'hDB, 8'hED);
    chk("fld_st0_pop", ONE, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    ex(8'hDB, 8'hED, 80'h4000_C000_0000_0000_0000);
    ex(8'hD9, 8'hE8); ex(8'hDD, 8'hD9);
    chk("fstp_sti", ONE, 16'h3800, 16'h3FFF, 16'h037F, 1'b0);
    ex(8'hDB, 8'hED);
    chk("fstp_sti_pop", ONE, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    for (int i = 0; i < 9; i++) ex(8'hD9, 8'hE8);
    chk("ovf_masked", ONE, 16'h3A41, 16'h8000, 16'h037F, 1'b0);
    ex_cw(8'hDB, 8'hE3, 16'h037E);
    chk("finit_cw", ONE, 16'h0000, 16'hFFFF, 16'h037E, 1'b0);
    for (int i = 0; i < 9; i++) ex(8'hD9, 8'hE8);
    chk("ovf_unmasked", ONE, 16'h82C1, 16'h0000, 16'h037E, 1'b1);
    ex(8'hDB, 8'hE3);
    chk("finit", ONE, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);

    ex(8'hDB, 8'h38);
    chk("unf_masked", INDEF, 16'h0841, 16'hFFFF, 16'h037F, 1'b0);
    ex_cw(8'hDB, 8'hE3, 16'h037E);
    ex(8'hDB, 8'h38);
    chk("unf_unmasked", INDEF, 16'h80C1, 16'hFFFF, 16'h037E, 1'b1);

    ex(8'hDB, 8'hE3);
    cw_only(16'h0272);
    ex(8'hD9, 8'hEB);
    do_reset();
    chk("reset_after_loads", 80'h0, 16'h0000, 16'hFFFF, 16'h037F, 1'b0);
    cw_only(16'h0272);
    chk("control_write", 80'h0, 16'h0000, 16'hFFFF, 16'h0272, 1'b0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
